// File: rtl/mest_pro_sequencer.sv
// mest_pro_sequencer: program sequencer for the MEST Pro datapath.
// Walks the instruction ROM from address 0 and issues each word to the ALU
// over a valid/ready handshake. It registers every result and flag set, and
// pulses o_all_done when it reaches a HALT opcode or the last ROM address.
// Optional watchdog: define MEST_PRO_SEQ_TIMEOUT_EN to enable it.
module mest_pro_sequencer #(
  parameter int                      OP_CODE_SIZE     = 4,
  parameter int                      DATA_W           = 8,
  parameter int                      ADDR_W           = 16,
  parameter int                      INSTRUCTION_SIZE = OP_CODE_SIZE + 3 * DATA_W,
  parameter logic [OP_CODE_SIZE-1:0] HALT_OPCODE      = '1,
  parameter int                      TIMEOUT_CYCLES   = 255
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  output logic                        o_rom_en,
  output logic [ADDR_W-1:0]           o_rom_addr,
  input  logic [INSTRUCTION_SIZE-1:0] i_rom_data,
  output logic                        o_alu_valid,
  input  logic                        i_alu_ready,
  output logic [OP_CODE_SIZE-1:0]     o_opcode,
  output logic [DATA_W-1:0]           o_operand_a,
  output logic [DATA_W-1:0]           o_operand_b,
  output logic [DATA_W-1:0]           o_operand_dest,
  input  logic                        i_alu_result_valid,
  input  logic [DATA_W-1:0]           i_alu_result,
  input  logic                        i_alu_carry,
  input  logic                        i_alu_zero,
  output logic [DATA_W-1:0]           o_result,
  output logic                        o_valid_result,
  output logic                        o_carry,
  output logic                        o_zero_flag,
  output logic                        o_all_done,
  output logic                        o_busy,
  output logic                        o_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_ISSUE,
    S_WAIT_RES,
    S_DONE
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   pc;
  logic                pc_last;
  logic                res_take;
  logic                timeout_hit;
  logic                rom_is_halt;

  assign rom_is_halt = (i_rom_data[INSTRUCTION_SIZE-1 -: OP_CODE_SIZE] == HALT_OPCODE);
  assign pc_last     = (pc == '1);
  assign res_take    = (state == S_WAIT_RES) && i_alu_result_valid && !timeout_hit;
  assign o_rom_addr  = pc;
  assign o_busy      = (state != S_IDLE);

`ifdef MEST_PRO_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             error_q;

  // The expiry cycle is the last ISSUE/WAIT_RES cycle. Valid is dropped in that cycle so a handshake cannot race the abort.
  assign timeout_hit = ((state == S_ISSUE) || (state == S_WAIT_RES)) &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign o_error     = error_q;

  // Watchdog counter: restarted on the way into ISSUE. The error stays set until the next accepted start.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      tmo_cnt <= '0;
      error_q <= 1'b0;
    end else begin
      if (state == S_WAIT_ROM)
        tmo_cnt <= '0;
      else if ((state == S_ISSUE) || (state == S_WAIT_RES))
        tmo_cnt <= tmo_cnt + TMO_W'(1);

      if ((state == S_IDLE) && i_start)
        error_q <= 1'b0;
      else if (timeout_hit)
        error_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign o_error        = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state decode and the per-state strobes
  always_comb begin
    state_d     = state;
    o_rom_en    = 1'b0;
    o_alu_valid = 1'b0;
    o_all_done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start) state_d = S_FETCH;
      end
      S_FETCH: begin
        o_rom_en = 1'b1;
        state_d  = S_WAIT_ROM;
      end
      S_WAIT_ROM: begin
        state_d = rom_is_halt ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        o_alu_valid = !timeout_hit;
        if (timeout_hit)      state_d = S_DONE;
        else if (i_alu_ready) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (timeout_hit)             state_d = S_DONE;
        else if (i_alu_result_valid) state_d = pc_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        o_all_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, program counter, latched instruction payload and the registered result
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state          <= S_IDLE;
      pc             <= '0;
      o_opcode       <= '0;
      o_operand_a    <= '0;
      o_operand_b    <= '0;
      o_operand_dest <= '0;
      o_result       <= '0;
      o_carry        <= 1'b0;
      o_zero_flag    <= 1'b0;
      o_valid_result <= 1'b0;
    end else begin
      state          <= state_d;
      o_valid_result <= res_take;

      if (res_take) begin
        o_result    <= i_alu_result;
        o_carry     <= i_alu_carry;
        o_zero_flag <= i_alu_zero;
      end

      // pc is cleared in DONE as well as IDLE, so the address already reads 0 once the sequencer is idle.
      if ((state == S_IDLE) || (state == S_DONE))
        pc <= '0;
      else if (res_take && !pc_last)
        pc <= pc + ADDR_W'(1);

      if ((state == S_WAIT_ROM) && !rom_is_halt) begin
        o_opcode       <= i_rom_data[INSTRUCTION_SIZE-1 -: OP_CODE_SIZE];
        o_operand_a    <= i_rom_data[3*DATA_W-1 -: DATA_W];
        o_operand_b    <= i_rom_data[2*DATA_W-1 -: DATA_W];
        o_operand_dest <= i_rom_data[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mest_pro_sequencer.sv
// tb_mest_pro_sequencer: the bench supplies a ROM array and a randomized ALU.
// A reference model is derived from the ROM contents and the rule that
// execution stops at the first HALT or at the end of the ROM. A scoreboard
// compares the DUT against that model. The ROM is kept small (ADDR_W=3) so
// that programs without a HALT also run to the end of the ROM.
module tb_mest_pro_sequencer;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int IW    = 28;

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          i_start;
  logic          o_rom_en;
  logic [AW-1:0] o_rom_addr;
  logic [IW-1:0] i_rom_data = '0;
  logic          o_alu_valid;
  logic          i_alu_ready;
  logic [3:0]    o_opcode;
  logic [7:0]    o_operand_a, o_operand_b, o_operand_dest;
  logic          i_alu_result_valid;
  logic [7:0]    i_alu_result;
  logic          i_alu_carry, i_alu_zero;
  logic [7:0]    o_result;
  logic          o_valid_result, o_carry, o_zero_flag, o_all_done, o_busy, o_error;

  always #5 clk = ~clk;

  mest_pro_sequencer #(
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk               (clk),
    .i_reset_n         (i_reset_n),
    .i_start           (i_start),
    .o_rom_en          (o_rom_en),
    .o_rom_addr        (o_rom_addr),
    .i_rom_data        (i_rom_data),
    .o_alu_valid       (o_alu_valid),
    .i_alu_ready       (i_alu_ready),
    .o_opcode          (o_opcode),
    .o_operand_a       (o_operand_a),
    .o_operand_b       (o_operand_b),
    .o_operand_dest    (o_operand_dest),
    .i_alu_result_valid(i_alu_result_valid),
    .i_alu_result      (i_alu_result),
    .i_alu_carry       (i_alu_carry),
    .i_alu_zero        (i_alu_zero),
    .o_result          (o_result),
    .o_valid_result    (o_valid_result),
    .o_carry           (o_carry),
    .o_zero_flag       (o_zero_flag),
    .o_all_done        (o_all_done),
    .o_busy            (o_busy),
    .o_error           (o_error)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bench ALU: returns {carry, zero, result}
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (op)
      4'd0:    s = {1'b0, a} + {1'b0, b};
      4'd1:    s = {1'b0, a} - {1'b0, b};
      4'd2:    s = {1'b0, a & b};
      4'd3:    s = {1'b0, a ^ b};
      default: s = {1'b0, a | b};
    endcase
    return {s[8], (s[7:0] == 8'd0), s[7:0]};
  endfunction

  // ROM: data valid one cycle after the read enable
  logic [IW-1:0] rom [DEPTH];
  always @(posedge clk) if (o_rom_en) i_rom_data <= rom[o_rom_addr];

  // ALU environment controls
  int rdy_mode = 1;   // 0 never ready, 1 always ready, 2 random
  int rdy_pct  = 100;
  int dly_min  = 0;
  int dly_max  = 0;
  bit spurious = 1'b0;

  logic       hs_q = 1'b0;
  logic [3:0] hs_op = '0;
  logic [7:0] hs_a = '0, hs_b = '0;
  always @(posedge clk) begin
    hs_q  <= o_alu_valid & i_alu_ready;
    hs_op <= o_opcode;
    hs_a  <= o_operand_a;
    hs_b  <= o_operand_b;
  end

  initial begin : alu_drv
    int cnt;
    bit pend;
    logic [9:0] r;
    i_alu_ready = 1'b0; i_alu_result_valid = 1'b0;
    i_alu_result = '0; i_alu_carry = 1'b0; i_alu_zero = 1'b0;
    pend = 1'b0; cnt = 0; r = '0;
    forever begin
      @(posedge clk); #1;
      i_alu_result_valid = 1'b0;
      if (hs_q) begin
        pend = 1'b1;
        cnt  = $urandom_range(dly_max, dly_min);
        r    = alu_fn(hs_op, hs_a, hs_b);
      end
      if (pend) begin
        if (cnt == 0) begin
          i_alu_result_valid = 1'b1;
          {i_alu_carry, i_alu_zero, i_alu_result} = r;
          pend = 1'b0;
        end else cnt--;
      end else if (spurious && o_alu_valid && ($urandom_range(3, 0) == 0)) begin
        i_alu_result_valid = 1'b1;
        {i_alu_carry, i_alu_zero, i_alu_result} = 10'($urandom);
      end
      case (rdy_mode)
        0:       i_alu_ready = 1'b0;
        1:       i_alu_ready = 1'b1;
        default: i_alu_ready = ($urandom_range(99, 0) < rdy_pct);
      endcase
    end
  end

  // Reference model: number of issued instructions and ROM fetches for the loaded program
  int n_ops, exp_fetches;
  int fetch_cnt, issue_idx, res_idx, done_cnt;
  bit mon_en = 1'b0;

  task automatic load_prog(input int halt_at);
    logic [7:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      a = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
      rom[i] = {4'($urandom_range(14, 0)), a, 8'($urandom), 8'($urandom)};
    end
    if (halt_at < DEPTH) rom[halt_at][27:24] = 4'hF;
    n_ops       = (halt_at < DEPTH) ? halt_at : DEPTH;
    exp_fetches = (halt_at < DEPTH) ? halt_at + 1 : DEPTH;
    fetch_cnt = 0; issue_idx = 0; res_idx = 0; done_cnt = 0;
  endtask

  task automatic monitor();
    logic [IW-1:0] w;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (o_rom_en) begin
          check("rom_addr", 64'(o_rom_addr), 64'(fetch_cnt));
          fetch_cnt++;
        end
        if (o_alu_valid && i_alu_ready) begin
          if (issue_idx < n_ops)
            check("payload", {o_opcode, o_operand_a, o_operand_b, o_operand_dest}, rom[issue_idx]);
          else
            check("extra_issue", 64'(issue_idx), 64'(n_ops));
          issue_idx++;
        end
        if (o_valid_result) begin
          if (res_idx < n_ops) begin
            w = rom[res_idx];
            check("result", {o_carry, o_zero_flag, o_result}, alu_fn(w[27:24], w[23:16], w[15:8]));
          end else
            check("extra_result", 64'(res_idx), 64'(n_ops));
          res_idx++;
        end
        if (o_all_done) done_cnt++;
      end
    end
  endtask

  task automatic start_prog();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic finish_prog(input string tag);
    for (int c = 0; c < 400 && done_cnt == 0; c++) @(negedge clk);
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
    check({tag, "_fetches"}, 64'(fetch_cnt), 64'(exp_fetches));
    check({tag, "_issues"},  64'(issue_idx), 64'(n_ops));
    check({tag, "_results"}, 64'(res_idx),   64'(n_ops));
    check({tag, "_dones"},   64'(done_cnt),  64'd1);
    check({tag, "_idle"},    {o_busy, o_error}, 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_rom_en, o_rom_addr, o_alu_valid, o_opcode, o_operand_a, o_operand_b,
                o_operand_dest, o_result, o_valid_result, o_carry, o_zero_flag,
                o_all_done, o_busy, o_error});
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [27:0] p0;
    int vc, vr, bad;
    bit chg;
    i_reset_n = 1'b0; i_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    n_ops = 0; exp_fetches = 0;
    fetch_cnt = 0; issue_idx = 0; res_idx = 0; done_cnt = 0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 i_reset_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);

    // Cycle-exact latency: {ADD,3,4,0},{HALT}
    load_prog(1);
    rom[0] = {4'd0, 8'd3, 8'd4, 8'd0};
    rdy_mode = 1; dly_min = 0; dly_max = 0; spurious = 1'b0; mon_en = 1'b1;
    start_prog();
    @(negedge clk); check("lat_rom_en_c1", {o_rom_en, o_rom_addr}, {1'b1, 3'd0});
    @(negedge clk); check("lat_c2", {o_rom_en, o_alu_valid}, 64'd0);
    @(negedge clk); check("lat_alu_valid_c3", {o_alu_valid, o_opcode, o_operand_a, o_operand_b}, {1'b1, 4'd0, 8'd3, 8'd4});
    @(negedge clk); check("lat_c4", 64'(o_valid_result), 64'd0);
    @(negedge clk); check("lat_result_c5", {o_valid_result, o_result, o_carry, o_zero_flag, o_rom_en, o_rom_addr},
                          {1'b1, 8'd7, 1'b0, 1'b0, 1'b1, 3'd1});
    @(negedge clk);
    @(negedge clk); check("lat_all_done_c7", 64'(o_all_done), 64'd1);
    @(negedge clk); check("lat_c8", {o_all_done, o_busy}, 64'd0);
    finish_prog("add34");

    // Empty program
    load_prog(0);
    start_prog();
    repeat (2) @(negedge clk);
    @(negedge clk); check("empty_done_c3", 64'(o_all_done), 64'd1);
    finish_prog("empty");
    check("empty_result_held", {o_result, o_carry, o_zero_flag}, {8'd7, 1'b0, 1'b0});

    // Carry / zero boundary
    load_prog(1);
    rom[0] = {4'd0, 8'hFF, 8'h01, 8'd0};
    rdy_mode = 2; rdy_pct = 60; dly_max = 2;
    start_prog();
    finish_prog("carry");
    check("carry_flags", {o_result, o_carry, o_zero_flag}, {8'd0, 1'b1, 1'b1});

    // Ready held low for 5 cycles
    load_prog(2);
    rdy_mode = 0; dly_max = 0;
    start_prog();
    for (int c = 0; c < 20 && !o_alu_valid; c++) @(negedge clk);
    p0 = {o_opcode, o_operand_a, o_operand_b, o_operand_dest};
    vc = 0; chg = 1'b0;
    for (int c = 0; c < 20 && o_alu_valid; c++) begin
      vc++;
      if ({o_opcode, o_operand_a, o_operand_b, o_operand_dest} != p0) chg = 1'b1;
      if (vc == 5) rdy_mode = 1;
      @(negedge clk);
    end
    check("stall_valid_cycles", 64'(vc), 64'd6);
    check("stall_payload_stable", 64'(chg), 64'd0);
    finish_prog("stall");

    // Reset during WAIT_RES, late result must be ignored
    load_prog(3);
    rdy_mode = 1; dly_min = 3; dly_max = 3;
    start_prog();
    for (int c = 0; c < 20 && !(o_alu_valid && i_alu_ready); c++) @(negedge clk);
    check("rst_handshake_seen", 64'(o_alu_valid && i_alu_ready), 64'd1);
    @(posedge clk); #1;
    mon_en = 1'b0; i_reset_n = 1'b0;
    @(posedge clk); #1 i_reset_n = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", all_outs(), 64'd0);
    vr = 0;
    repeat (6) begin @(negedge clk); if (o_valid_result || o_busy) vr++; end
    check("rst_late_result_ignored", 64'(vr), 64'd0);
    fetch_cnt = 0; issue_idx = 0; res_idx = 0; done_cnt = 0;
    dly_min = 0; dly_max = 3; mon_en = 1'b1;
    start_prog();
    finish_prog("after_rst");

    // No HALT: runs to the last address, start re-pulse ignored
    load_prog(DEPTH);
    rdy_mode = 2; rdy_pct = 70; spurious = 1'b1;
    start_prog();
    repeat (8) @(negedge clk);
    start_prog();
    finish_prog("nohalt");

    // Randomized programs
    for (int t = 0; t < 12; t++) begin
      load_prog($urandom_range(DEPTH, 0));
      rdy_pct = $urandom_range(100, 30);
      dly_max = $urandom_range(3, 0);
      start_prog();
      finish_prog($sformatf("rand%0d", t));
    end

    // Watchdog behaviour with the ALU never ready
    mon_en = 1'b0; spurious = 1'b0; rdy_mode = 0;
    load_prog(1);
    start_prog();
`ifdef MEST_PRO_SEQ_TIMEOUT_EN
    for (int c = 0; c < 20 && !o_alu_valid; c++) @(negedge clk);
    vc = 0;
    for (int c = 0; c < 40 && !o_all_done; c++) begin vc++; @(negedge clk); end
    check("tmo_cycles", 64'(vc), 64'd10);
    check("tmo_error", {o_all_done, o_error}, {1'b1, 1'b1});
    start_prog();
    @(negedge clk);
    check("tmo_error_cleared", 64'(o_error), 64'd0);
`else
    bad = 0;
    repeat (300) begin @(negedge clk); if (!o_busy || o_error) bad++; end
    check("no_tmo_busy_held", 64'(bad), 64'd0);
`endif
    @(posedge clk); #1 i_reset_n = 1'b0;
    @(posedge clk); #1 i_reset_n = 1'b1;
    @(negedge clk);
    check("final_reset", all_outs(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
